// File: rtl/corr_pkg.sv
// Shared definitions for the correlation scan controller and correlation-score unit.
package corr_pkg;

  // Window origin coordinate width shared with the correlation unit.
  localparam int unsigned COORD_W = 13;

  // Default score width.
  localparam int unsigned SCORE_W_DEF = 32;

  // Search template size shared with the correlation unit.
  localparam int unsigned SEARCH_H_RES_DEF = 32;
  localparam int unsigned SEARCH_V_RES_DEF = 32;

  // Scan controller states.
  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StArm,
    StWait,
    StCompare,
    StAdvance,
    StDone
  } scan_state_e;

endpackage

// File: rtl/corr_best_tracker.sv
// Best-score register set: clears on scan start and keeps the strictly higher
// score offered while update is enabled. On a tie the earlier position is kept.
module corr_best_tracker
  import corr_pkg::*;
#(
  parameter int unsigned SCORE_W = SCORE_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               upd_en_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [SCORE_W-1:0] score_i,
  output logic [COORD_W-1:0] best_x_o,
  output logic [COORD_W-1:0] best_y_o,
  output logic [SCORE_W-1:0] best_score_o,
  output logic               best_valid_o
);

  logic [COORD_W-1:0] best_x_q, best_x_d;
  logic [COORD_W-1:0] best_y_q, best_y_d;
  logic [SCORE_W-1:0] best_score_q, best_score_d;
  logic               best_valid_q, best_valid_d;
  logic               take;

  // The first result after a clear is always taken; later ones only if strictly better.
  assign take = upd_en_i && (!best_valid_q || (score_i > best_score_q));

  // Next-state: clear has priority over update.
  always_comb begin
    best_x_d     = best_x_q;
    best_y_d     = best_y_q;
    best_score_d = best_score_q;
    best_valid_d = best_valid_q;
    if (clr_i) begin
      best_x_d     = '0;
      best_y_d     = '0;
      best_score_d = '0;
      best_valid_d = 1'b0;
    end else if (take) begin
      best_x_d     = x_i;
      best_y_d     = y_i;
      best_score_d = score_i;
      best_valid_d = 1'b1;
    end
  end

  // Best-result registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      best_x_q     <= '0;
      best_y_q     <= '0;
      best_score_q <= '0;
      best_valid_q <= 1'b0;
    end else begin
      best_x_q     <= best_x_d;
      best_y_q     <= best_y_d;
      best_score_q <= best_score_d;
      best_valid_q <= best_valid_d;
    end
  end

  assign best_x_o     = best_x_q;
  assign best_y_o     = best_y_q;
  assign best_score_o = best_score_q;
  assign best_valid_o = best_valid_q;

endmodule

// File: rtl/corr_scan_ctrl.sv
// Correlation scan controller: rasters the window origin over the frame, launches
// one correlation per position, waits for a fresh finished edge and tracks the best.
// Optional early exit on a score at or above EARLY_EXIT_SCORE is enabled by defining
// CORR_SCAN_EARLY_EXIT_EN.
module corr_scan_ctrl
  import corr_pkg::*;
#(
  parameter int unsigned       FRAME_H_RES      = 640,
  parameter int unsigned       FRAME_V_RES      = 480,
  parameter int unsigned       SEARCH_H_RES     = SEARCH_H_RES_DEF,
  parameter int unsigned       SEARCH_V_RES     = SEARCH_V_RES_DEF,
  parameter int unsigned       STEP             = 4,
  parameter int unsigned       SCORE_W          = SCORE_W_DEF,
  parameter logic [SCORE_W-1:0] EARLY_EXIT_SCORE = {SCORE_W{1'b1}}
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iStart,
  input  logic               iAbort,
  output logic               oBusy,
  output logic               oDone,
  output logic [COORD_W-1:0] oXstart,
  output logic [COORD_W-1:0] oYstart,
  output logic               oCorrStart,
  input  logic               iCorrFinished,
  input  logic [SCORE_W-1:0] iScore,
  output logic [COORD_W-1:0] oBestX,
  output logic [COORD_W-1:0] oBestY,
  output logic [SCORE_W-1:0] oBestScore,
  output logic               oBestValid
);

  // Elaboration-time parameter sanity checks.
  if (SEARCH_H_RES > FRAME_H_RES) begin : g_bad_h_res
    $error("corr_scan_ctrl: SEARCH_H_RES exceeds FRAME_H_RES");
  end
  if (SEARCH_V_RES > FRAME_V_RES) begin : g_bad_v_res
    $error("corr_scan_ctrl: SEARCH_V_RES exceeds FRAME_V_RES");
  end
  if (STEP == 0) begin : g_bad_step
    $error("corr_scan_ctrl: STEP must be greater than zero");
  end
  if ((FRAME_H_RES >= (1 << COORD_W)) || (FRAME_V_RES >= (1 << COORD_W))) begin : g_bad_frame
    $error("corr_scan_ctrl: frame size does not fit the coordinate width");
  end

  // Position arithmetic is one bit wider than the coordinates so X+STEP cannot wrap.
  localparam logic [COORD_W:0] XMax  = (COORD_W + 1)'(FRAME_H_RES - SEARCH_H_RES);
  localparam logic [COORD_W:0] YMax  = (COORD_W + 1)'(FRAME_V_RES - SEARCH_V_RES);
  localparam logic [COORD_W:0] StepW = (COORD_W + 1)'(STEP);

`ifdef CORR_SCAN_EARLY_EXIT_EN
  localparam bit EarlyExitEn = 1'b1;
`else
  localparam bit EarlyExitEn = 1'b0;
`endif

  scan_state_e        state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               prev_q, prev_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [COORD_W:0]   x_inc, y_inc;
  logic               early_hit;
  logic               best_clr;
  logic               best_upd;

  assign x_inc     = {1'b0, x_q} + StepW;
  assign y_inc     = {1'b0, y_q} + StepW;
  assign early_hit = EarlyExitEn && (score_q >= EARLY_EXIT_SCORE);

  // Next-state, position stepping and best-tracker control; abort overrides everything.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    prev_d   = prev_q;
    score_d  = score_q;
    best_clr = 1'b0;
    best_upd = 1'b0;
    if (iAbort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (iStart) begin
            state_d  = StLaunch;
            x_d      = '0;
            y_d      = '0;
            best_clr = 1'b1;
          end
        end
        StLaunch: state_d = StArm;
        StArm: begin
          // Snapshot the finished level so a stale high from the last position is not taken.
          prev_d  = iCorrFinished;
          state_d = StWait;
        end
        StWait: begin
          prev_d = iCorrFinished;
          if (!prev_q && iCorrFinished) begin
            score_d = iScore;
            state_d = StCompare;
          end
        end
        StCompare: begin
          best_upd = 1'b1;
          state_d  = early_hit ? StDone : StAdvance;
        end
        StAdvance: begin
          if (x_inc <= XMax) begin
            x_d     = x_inc[COORD_W-1:0];
            state_d = StLaunch;
          end else if (y_inc <= YMax) begin
            x_d     = '0;
            y_d     = y_inc[COORD_W-1:0];
            state_d = StLaunch;
          end else begin
            state_d = StDone;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Controller state registers with synchronous active-low reset.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      prev_q  <= 1'b0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      prev_q  <= prev_d;
      score_q <= score_d;
    end
  end

  corr_best_tracker #(
    .SCORE_W (SCORE_W)
  ) u_best (
    .clk_i        (iCLK),
    .rst_ni       (iRST_N),
    .clr_i        (best_clr),
    .upd_en_i     (best_upd),
    .x_i          (x_q),
    .y_i          (y_q),
    .score_i      (score_q),
    .best_x_o     (oBestX),
    .best_y_o     (oBestY),
    .best_score_o (oBestScore),
    .best_valid_o (oBestValid)
  );

  assign oBusy      = (state_q != StIdle) && (state_q != StDone);
  assign oDone      = (state_q == StDone);
  assign oCorrStart = (state_q == StLaunch);
  assign oXstart    = x_q;
  assign oYstart    = y_q;

endmodule

// File: tb/tb_corr_scan_ctrl.sv
// Bench for corr_scan_ctrl on a 16x8 frame, 4x4 template, step 4 (8 positions).
// Honours CORR_SCAN_EARLY_EXIT_EN with an early-exit threshold of 9.
module tb_corr_scan_ctrl;

  localparam int FH = 16;
  localparam int FV = 8;
  localparam int SH = 4;
  localparam int SV = 4;
  localparam int ST = 4;
  localparam int XMAX = FH - SH;
  localparam int YMAX = FV - SV;
  localparam logic [31:0] THR = 32'd9;
`ifdef CORR_SCAN_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        corr_fin;
  logic [31:0] score = '0;
  logic        busy, done, corr_start, best_valid;
  logic [12:0] xs, ys, best_x, best_y;
  logic [31:0] best_score;

  corr_scan_ctrl #(
    .FRAME_H_RES      (FH),
    .FRAME_V_RES      (FV),
    .SEARCH_H_RES     (SH),
    .SEARCH_V_RES     (SV),
    .STEP             (ST),
    .SCORE_W          (32),
    .EARLY_EXIT_SCORE (THR)
  ) dut (
    .iCLK          (clk),
    .iRST_N        (rst_n),
    .iStart        (start),
    .iAbort        (abort),
    .oBusy         (busy),
    .oDone         (done),
    .oXstart       (xs),
    .oYstart       (ys),
    .oCorrStart    (corr_start),
    .iCorrFinished (corr_fin),
    .iScore        (score),
    .oBestX        (best_x),
    .oBestY        (best_y),
    .oBestScore    (best_score),
    .oBestValid    (best_valid)
  );

  always #10 clk = ~clk;

  // Behavioural correlation unit: finished rises 10 cycles after a launch and stays high.
  logic [7:0][31:0] score_tab = '0;
  logic stale_mode = 1'b0;
  logic force_low  = 1'b0;
  logic fin_q      = 1'b0;
  int   cnt        = 0;
  int   model_idx  = 0;

  assign corr_fin = fin_q && !force_low;

  always @(negedge clk) begin
    if (!rst_n) begin
      fin_q <= 1'b0;
      cnt   <= 0;
    end else if (corr_start) begin
      if (!stale_mode) fin_q <= 1'b0;
      cnt   <= 10;
      score <= score_tab[model_idx[2:0]];
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) fin_q <= 1'b1;
    end
    if (!busy) model_idx <= 0;
    else if (corr_start) model_idx <= model_idx + 1;
  end

  // Bench bookkeeping.
  int n_checks = 0;
  int n_pass   = 0;
  logic [12:0] lx[$];
  logic [12:0] ly[$];
  logic [12:0] rx[$];
  logic [12:0] ry[$];
  int done_seen = 0;

  typedef struct packed {
    logic [7:0][31:0] sc;
    logic [3:0]       n;
    logic [31:0]      bs;
    logic [12:0]      bx;
    logic [12:0]      by;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step_cycle();
    @(negedge clk);
    if (corr_start) begin
      lx.push_back(xs);
      ly.push_back(ys);
    end
    if (done) done_seen++;
  endtask

  task automatic begin_scan();
    lx.delete();
    ly.delete();
    done_seen = 0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) step_cycle();
    rst_n = 1'b1;
    step_cycle();
  endtask

  // Full scan from a start pulse; optionally re-pulse start while busy.
  task automatic run_scan(input bit poke);
    begin_scan();
    start = 1'b1;
    step_cycle();
    start = 1'b0;
    for (int c = 0; c < 400 && done_seen == 0; c++) begin
      start = poke && (c == 14 || c == 20);
      step_cycle();
    end
    start = 1'b0;
    repeat (4) step_cycle();
  endtask

  task automatic check_scan(input string tag, input int en, input logic [31:0] bs,
                            input logic [12:0] bx, input logic [12:0] by);
    check({tag, "_launches"}, lx.size(), en);
    for (int i = 0; i < en && i < lx.size(); i++)
      check($sformatf("%s_pos%0d", tag, i), {lx[i], ly[i]}, {rx[i], ry[i]});
    check({tag, "_done_pulses"}, done_seen, 1);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_valid"}, best_valid, 1);
    check({tag, "_best_score"}, best_score, bs);
    check({tag, "_best_xy"}, {best_x, best_y}, {bx, by});
  endtask

  // Reference: visit raster positions in order, keep first strictly-best score.
  task automatic ref_scan(input logic [7:0][31:0] sc, output int n, output logic [31:0] bs,
                          output logic [12:0] bx, output logic [12:0] by);
    bit have;
    have = 1'b0;
    n = 0;
    bs = '0;
    bx = '0;
    by = '0;
    for (int i = 0; i < rx.size(); i++) begin
      n = i + 1;
      if (!have || sc[i] > bs) begin
        have = 1'b1;
        bs = sc[i];
        bx = rx[i];
        by = ry[i];
      end
      if (EE && sc[i] >= THR) break;
    end
  endtask

  function automatic logic [7:0][31:0] mk(input int unsigned a0, a1, a2, a3, a4, a5, a6, a7);
    logic [7:0][31:0] r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
    return r;
  endfunction

  initial begin
    logic [7:0][31:0] sc;
    int               en;
    logic [31:0]      bs;
    logic [12:0]      bx, by;

    for (int y = 0; y <= YMAX; y += ST)
      for (int x = 0; x <= XMAX; x += ST) begin
        rx.push_back(13'(x));
        ry.push_back(13'(y));
      end

    vt[0] = '{sc: mk(5, 9, 9, 3, 12, 12, 1, 0),
              n: EE ? 4'd2 : 4'd8, bs: EE ? 32'd9 : 32'd12,
              bx: EE ? 13'd4 : 13'd0, by: EE ? 13'd0 : 13'd4};
    vt[1] = '{sc: mk(7, 7, 7, 7, 7, 7, 7, 7), n: 4'd8, bs: 32'd7, bx: 13'd0, by: 13'd0};
    vt[2] = '{sc: mk(1, 2, 3, 4, 5, 6, 7, 8), n: 4'd8, bs: 32'd8, bx: 13'd12, by: 13'd4};
    vt[3] = '{sc: mk(0, 0, 0, 0, 0, 0, 0, 0), n: 4'd8, bs: 32'd0, bx: 13'd0, by: 13'd0};
    vt[4] = '{sc: mk(3, 1, 4, 1, 5, 32'hFFFF_FFFF, 2, 6),
              n: EE ? 4'd6 : 4'd8, bs: 32'hFFFF_FFFF, bx: 13'd4, by: 13'd4};
    vt[5] = '{sc: mk(8, 32'h8000_0000, 7, 6, 5, 4, 3, 2),
              n: EE ? 4'd2 : 4'd8, bs: 32'h8000_0000, bx: 13'd4, by: 13'd0};

    // Reset state.
    reset_dut();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_corr_start", corr_start, 0);
    check("reset_xy", {xs, ys}, 0);
    check("reset_best", {best_valid, best_x, best_y, best_score}, 0);

    // Table-driven scans; vector 1 also pulses start while busy.
    for (int i = 0; i < 6; i++) begin
      score_tab = vt[i].sc;
      run_scan(i == 1);
      check_scan($sformatf("vec%0d", i), int'(vt[i].n), vt[i].bs, vt[i].bx, vt[i].by);
    end

    // Randomised scans against the reference.
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 8; j++) sc[j] = $urandom_range(0, 12);
      score_tab = sc;
      ref_scan(sc, en, bs, bx, by);
      run_scan(1'b0);
      check_scan($sformatf("rand%0d", k), en, bs, bx, by);
    end

    // Stale finished: stall on second position until finished drops and re-rises.
    reset_dut();
    stale_mode = 1'b1;
    score_tab = mk(5, 6, 1, 2, 3, 4, 0, 1);
    begin_scan();
    start = 1'b1;
    step_cycle();
    start = 1'b0;
    repeat (60) step_cycle();
    check("stale_launches", lx.size(), 2);
    check("stale_no_done", done_seen, 0);
    check("stale_busy", busy, 1);
    check("stale_best_score", best_score, 5);
    stale_mode = 1'b0;
    @(posedge clk);
    #1;
    force_low = 1'b1;
    @(posedge clk);
    #1;
    force_low = 1'b0;
    for (int c = 0; c < 300 && done_seen == 0; c++) step_cycle();
    repeat (3) step_cycle();
    check_scan("stale_resume", 8, 32'd6, 13'd4, 13'd0);

    // Abort during the third WAIT keeps partial results and gives no done.
    score_tab = mk(4, 7, 20, 2, 2, 2, 2, 2);
    begin_scan();
    start = 1'b1;
    step_cycle();
    start = 1'b0;
    for (int c = 0; c < 200 && lx.size() < 3; c++) step_cycle();
    check("abort_reach_third", lx.size(), 3);
    repeat (5) step_cycle();
    abort = 1'b1;
    step_cycle();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done_seen, 0);
    check("abort_partial", {best_valid, best_x, best_y, best_score}, {1'b1, 13'd4, 13'd0, 32'd7});
    repeat (20) step_cycle();
    check("abort_no_resume", {lx.size(), done_seen}, {32'd3, 32'd0});

    // Abort and start together in IDLE: start dropped, best untouched.
    start = 1'b1;
    abort = 1'b1;
    step_cycle();
    start = 1'b0;
    abort = 1'b0;
    repeat (5) step_cycle();
    check("abort_start_drop", {busy, lx.size()}, {1'b0, 32'd3});
    check("abort_start_best", {best_valid, best_score}, {1'b1, 32'd7});

    // Reset mid-scan clears every output.
    score_tab = mk(3, 3, 3, 3, 3, 3, 3, 3);
    begin_scan();
    start = 1'b1;
    step_cycle();
    start = 1'b0;
    for (int c = 0; c < 200 && lx.size() < 2; c++) step_cycle();
    repeat (4) step_cycle();
    check("pre_reset_valid", best_valid, 1);
    rst_n = 1'b0;
    step_cycle();
    check("midrst_ctrl", {busy, done, corr_start}, 0);
    check("midrst_xy", {xs, ys}, 0);
    check("midrst_best", {best_valid, best_x, best_y, best_score}, 0);
    rst_n = 1'b1;
    step_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
